vending_ctrl: RTL

VENDING_CTRL -- requirements
Module: vending_ctrl

---
 rtl/vending_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vending_ctrl.sv
// vending_ctrl -- coin-operated vending controller.
//
// Debounces asynchronous active-low keys, accumulates a pay total and an
// item total (saturating with sticky overflow flags), issues a one-cycle
// vend strobe when enough money has been inserted, then shows the change
// for HOLD_CYCLES cycles before clearing the session.
//
// Build option: define IR_SENSE_EN to enable IR item-present gating of the
// vend decision and drive litup from the synchronised ir_sig. Without it,
// litup is held low and ir_sig is unused.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   coin_key   [N_COIN-1:0] coin buttons, active-low, asynchronous
//   item_key   add-item button, active-low, asynchronous
//   vend_key   confirm button, active-low, asynchronous
//   ir_sig     IR item-present sensor (high = present), asynchronous
//   litup      registered IR indicator
//   vend_pulse one-cycle dispense strobe
//   seg0..seg5 active-low gfedcba digits:
//              seg1:seg0 change, seg3:seg2 item total, seg5:seg4 pay total

module vending_ctrl #(
    parameter int unsigned         N_COIN      = 2,
    parameter logic [N_COIN*7-1:0] COIN_VALS   = {7'd10, 7'd5},
    parameter int unsigned         PRICE       = 3,
    parameter int unsigned         MAX_TOTAL   = 99,
    parameter int unsigned         DB_CYCLES   = 64,
    parameter int unsigned         HOLD_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_COIN-1:0] coin_key,
    input  logic              item_key,
    input  logic              vend_key,
    input  logic              ir_sig,
    output logic              litup,
    output logic              vend_pulse,
    output logic [6:0]        seg0,
    output logic [6:0]        seg1,
    output logic [6:0]        seg2,
    output logic [6:0]        seg3,
    output logic [6:0]        seg4,
    output logic [6:0]        seg5
);

    // Key vector layout: coins in the low bits, then item, then vend.
    localparam int unsigned NK     = N_COIN + 2;
    localparam int unsigned K_ITEM = N_COIN;
    localparam int unsigned K_VEND = N_COIN + 1;

    localparam int unsigned    DBW       = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam int unsigned    HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [7:0]     MAX_T     = 8'(MAX_TOTAL);
    localparam logic [7:0]     PRICE8    = 8'(PRICE);

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        HOLD
    } state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Key synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [NK-1:0]  key_raw;
    logic [NK-1:0]  sync1, sync2;
    logic [NK-1:0]  cand;      // last synchronised level seen
    logic [NK-1:0]  acc;       // accepted (debounced) level
    logic [NK-1:0]  press;     // one-cycle 1->0 acceptance event
    logic [DBW-1:0] db_cnt [NK];

    assign key_raw = {vend_key, item_key, coin_key};

    // The counter restarts whenever the synchronised level moves; a new level
    // is accepted only after DB_CYCLES further stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            cand  <= '1;
            acc   <= '1;
            press <= '0;
            for (int unsigned k = 0; k < NK; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= '0;
            for (int unsigned k = 0; k < NK; k++) begin
                if (sync2[k] != cand[k]) begin
                    cand[k]   <= sync2[k];
                    db_cnt[k] <= '0;
                end else if (cand[k] != acc[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        acc[k]    <= cand[k];
                        db_cnt[k] <= '0;
                        press[k]  <= ~cand[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DBW'(1);
                    end
                end
            end
        end
    end

    logic item_press, vend_press;
    assign item_press = press[K_ITEM];
    assign vend_press = press[K_VEND];

    // Lowest-indexed coin wins when several land in the same cycle.
    logic       coin_hit;
    logic [6:0] coin_val;

    always_comb begin
        coin_hit = 1'b0;
        coin_val = '0;
        for (int unsigned i = 0; i < N_COIN; i++) begin
            if (press[i] && !coin_hit) begin
                coin_hit = 1'b1;
                coin_val = COIN_VALS[i*7 +: 7];
            end
        end
    end

    // ------------------------------------------------------------------
    // IR sensing
    // ------------------------------------------------------------------
    logic ir_ok;

`ifdef IR_SENSE_EN
    logic ir_s1, ir_s2, litup_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_s1   <= 1'b0;
            ir_s2   <= 1'b0;
            litup_r <= 1'b0;
        end else begin
            ir_s1   <= ir_sig;
            ir_s2   <= ir_s1;
            litup_r <= ir_s2;
        end
    end

    assign litup = litup_r;
    assign ir_ok = litup_r;
`else
    logic unused_ir;
    assign unused_ir = ir_sig;
    assign litup     = 1'b0;
    assign ir_ok     = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Totals and FSM
    // ------------------------------------------------------------------
    logic [6:0]    pay_tot, item_tot, change_r;
    logic          pay_ovf, item_ovf;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    pay_sum, item_sum;
    logic          take_press, hold_done, vend_ok;

    assign pay_sum  = {1'b0, pay_tot} + {1'b0, coin_val};
    assign item_sum = {1'b0, item_tot} + PRICE8;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        vend_ok  = vend_press && (item_tot != '0) && (pay_tot >= item_tot) && ir_ok;
        state_nx = state;
        case (state)
            IDLE:    if (coin_hit || item_press) state_nx = COLLECT;
            COLLECT: if (vend_ok) state_nx = VEND;
            VEND:    state_nx = HOLD;
            HOLD:    if (hold_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vend_pulse = (state == VEND);
        take_press = (state == IDLE) || (state == COLLECT);
        hold_done  = (state == HOLD) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst || hold_done) begin
            pay_tot  <= '0;
            item_tot <= '0;
            pay_ovf  <= 1'b0;
            item_ovf <= 1'b0;
            change_r <= '0;
            hold_cnt <= '0;
        end else begin
            if (take_press && coin_hit) begin
                if (pay_sum <= MAX_T) pay_tot <= pay_sum[6:0];
                else                  pay_ovf <= 1'b1;
            end
            if (take_press && item_press) begin
                if (item_sum <= MAX_T) item_tot <= item_sum[6:0];
                else                   item_ovf <= 1'b1;
            end
            if (state == VEND) begin
                change_r <= pay_tot - item_tot;
            end
            if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
            else               hold_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    // Shift-and-add-3 conversion; inputs never exceed 99 so two digits suffice.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        logic [14:0] sh;
        sh = {8'b0, bin};
        for (int unsigned i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7] + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            sh = sh << 1;
        end
        return sh[14:7];
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hF:    return 7'b0001110;
            default: return 7'b0111111;
        endcase
    endfunction

    logic [7:0] pay_bcd, item_bcd, chg_bcd;
    logic [6:0] diff;

    always_comb begin
        diff     = pay_tot - item_tot;
        pay_bcd  = pay_ovf  ? 8'hFF : bin_to_bcd(pay_tot);
        item_bcd = item_ovf ? 8'hFF : bin_to_bcd(item_tot);
        if (state == HOLD)           chg_bcd = bin_to_bcd(change_r);
        else if (pay_tot >= item_tot) chg_bcd = bin_to_bcd(diff);
        else                         chg_bcd = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg0 <= SEG_ZERO;
            seg1 <= SEG_ZERO;
            seg2 <= SEG_ZERO;
            seg3 <= SEG_ZERO;
            seg4 <= SEG_ZERO;
            seg5 <= SEG_ZERO;
        end else begin
            seg0 <= seg_code(chg_bcd[3:0]);
            seg1 <= seg_code(chg_bcd[7:4]);
            seg2 <= seg_code(item_bcd[3:0]);
            seg3 <= seg_code(item_bcd[7:4]);
            seg4 <= seg_code(pay_bcd[3:0]);
            seg5 <= seg_code(pay_bcd[7:4]);
        end
    end

endmodule
